dff_checker: RTL and testbench

Synthesizable response checker for the three-flavour D flip-flop block (no-reset, synchronous-reset and asynchronous-reset outputs). It observes the same `d_i` and DUT reset that drive the flop block and keeps a cycle-accurate reference model of all three flops. Every cycle it compares the model against the flop outputs and reports sticky error flags, a mismatch count and the cycle of the first failure. It sits beside the flop block in self-checking benches and on-chip bring-up.

---
 rtl/dff_checker.sv | 122 ++++++++++++
 tb/tb_dff_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dff_checker.sv
// Reference-model checker for the no-reset / sync-reset / async-reset flop trio.
// Compares observed flop outputs against a one-cycle-delayed model and keeps sticky error status.
module dff_checker #(
  parameter int CNT_W       = 8,
  parameter int CYC_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             dut_reset_i,
  input  logic             d_i,
  input  logic             q_norst_i,
  input  logic             q_syncrst_i,
  input  logic             q_asyncrst_i,
  output logic [1:0]       state_o,
  output logic             err_o,
  output logic [2:0]       err_mask_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CYC_W-1:0] cyc_cnt_o,
  output logic [CYC_W-1:0] first_err_cyc_o,
  output logic             first_err_valid_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             d_prev_q, d_prev_d;
  logic             rst_prev_q, rst_prev_d;
  logic             err_q, err_d;
  logic [2:0]       err_mask_q, err_mask_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CYC_W-1:0] first_err_cyc_q, first_err_cyc_d;
  logic             first_err_valid_q, first_err_valid_d;

  logic       exp_norst, exp_sync, exp_async;
  logic [2:0] mis;

  always_comb begin
    exp_norst = d_prev_q;
    exp_sync  = rst_prev_q ? 1'b0 : d_prev_q;
    // The async flop clears as soon as its reset rises, before the edge samples it.
    exp_async = (dut_reset_i | rst_prev_q) ? 1'b0 : d_prev_q;
    mis       = {q_asyncrst_i ^ exp_async, q_syncrst_i ^ exp_sync, q_norst_i ^ exp_norst};

    state_d           = state_q;
    d_prev_d          = d_i;
    rst_prev_d        = dut_reset_i;
    err_d             = err_q;
    err_mask_d        = err_mask_q;
    err_cnt_d         = err_cnt_q;
    cyc_cnt_d         = cyc_cnt_q;
    first_err_cyc_d   = first_err_cyc_q;
    first_err_valid_d = first_err_valid_q;

    case (state_q)
      IDLE: begin
        if (en_i) state_d = PRIME;
      end
      PRIME: begin
        state_d = en_i ? CHECK : IDLE;
      end
      CHECK: begin
        if (cyc_cnt_q != '1) cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        if (mis != 3'b000) begin
          err_d      = 1'b1;
          err_mask_d = err_mask_q | mis;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          if (!first_err_valid_q) begin
            first_err_cyc_d   = cyc_cnt_q;
            first_err_valid_d = 1'b1;
          end
        end
        if ((STOP_ON_ERR != 0) && (mis != 3'b000)) state_d = HALT;
        else if (!en_i)                            state_d = IDLE;
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      d_prev_q          <= 1'b0;
      rst_prev_q        <= 1'b0;
      err_q             <= 1'b0;
      err_mask_q        <= 3'b000;
      err_cnt_q         <= '0;
      cyc_cnt_q         <= '0;
      first_err_cyc_q   <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      d_prev_q          <= d_prev_d;
      rst_prev_q        <= rst_prev_d;
      err_q             <= err_d;
      err_mask_q        <= err_mask_d;
      err_cnt_q         <= err_cnt_d;
      cyc_cnt_q         <= cyc_cnt_d;
      first_err_cyc_q   <= first_err_cyc_d;
      first_err_valid_q <= first_err_valid_d;
    end
  end

  assign state_o           = state_q;
  assign err_o             = err_q;
  assign err_mask_o        = err_mask_q;
  assign err_cnt_o         = err_cnt_q;
  assign cyc_cnt_o         = cyc_cnt_q;
  assign first_err_cyc_o   = first_err_cyc_q;
  assign first_err_valid_o = first_err_valid_q;

endmodule

// File: tb/tb_dff_checker.sv
// Bench for dff_checker: three instances (default, 2-bit error counter, stop-on-error)
// share one directed stimulus stream driven through a behavioural flop trio.
module tb_dff_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, en = 1'b0, dut_rst = 1'b0, d = 1'b0;
  logic force_sync = 1'b0, force_async = 1'b0, inv_norst = 1'b0;

  // Behavioural flop block the checker watches.
  logic norst_r = 1'b0, sync_r = 1'b0, async_r = 1'b0;
  always @(posedge clk) begin
    norst_r <= d;
    sync_r  <= dut_rst ? 1'b0 : d;
  end
  always @(posedge clk or posedge dut_rst) begin
    if (dut_rst) async_r <= 1'b0;
    else         async_r <= d;
  end

  logic q_n, q_s, q_a;
  assign q_n = norst_r ^ inv_norst;
  assign q_s = force_sync ? 1'b1 : sync_r;
  assign q_a = force_async ? 1'b1 : async_r;

  logic [1:0]  st0, st1, st2;
  logic        er0, er1, er2;
  logic [2:0]  mk0, mk1, mk2;
  logic [7:0]  ec0, ec2;
  logic [1:0]  ec1;
  logic [15:0] cy0, cy1, cy2, fc0, fc1, fc2;
  logic        fv0, fv1, fv2;

  dff_checker u_def (
    .clk(clk), .reset(reset), .en_i(en), .dut_reset_i(dut_rst), .d_i(d),
    .q_norst_i(q_n), .q_syncrst_i(q_s), .q_asyncrst_i(q_a),
    .state_o(st0), .err_o(er0), .err_mask_o(mk0), .err_cnt_o(ec0), .cyc_cnt_o(cy0),
    .first_err_cyc_o(fc0), .first_err_valid_o(fv0));

  dff_checker #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .en_i(en), .dut_reset_i(dut_rst), .d_i(d),
    .q_norst_i(q_n), .q_syncrst_i(q_s), .q_asyncrst_i(q_a),
    .state_o(st1), .err_o(er1), .err_mask_o(mk1), .err_cnt_o(ec1), .cyc_cnt_o(cy1),
    .first_err_cyc_o(fc1), .first_err_valid_o(fv1));

  dff_checker #(.STOP_ON_ERR(1)) u_stop (
    .clk(clk), .reset(reset), .en_i(en), .dut_reset_i(dut_rst), .d_i(d),
    .q_norst_i(q_n), .q_syncrst_i(q_s), .q_asyncrst_i(q_a),
    .state_o(st2), .err_o(er2), .err_mask_o(mk2), .err_cnt_o(ec2), .cyc_cnt_o(cy2),
    .first_err_cyc_o(fc2), .first_err_valid_o(fv2));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 prime, 2 check, 3 halted; history of the last sampled d/reset.
  int m_mode[3], m_err[3], m_mask[3], m_ec[3], m_cyc[3], m_fc[3], m_fv[3];
  int ec_max[3]  = '{255, 3, 255};
  int stop_on[3] = '{0, 0, 1};
  int hist_d = 0, hist_r = 0;

  task automatic model_step(input int i, input int rst, input int e, input int dr, input int qn,
                            input int qs, input int qa);
    int want_n, want_s, want_a, bad;
    if (rst != 0) begin
      m_mode[i] = 0; m_err[i] = 0; m_mask[i] = 0; m_ec[i] = 0;
      m_cyc[i] = 0; m_fc[i] = 0; m_fv[i] = 0;
      return;
    end
    if (m_mode[i] == 0) begin
      if (e != 0) m_mode[i] = 1;
    end else if (m_mode[i] == 1) begin
      m_mode[i] = (e != 0) ? 2 : 0;
    end else if (m_mode[i] == 2) begin
      want_n = hist_d;
      want_s = (hist_r != 0) ? 0 : hist_d;
      want_a = (dr != 0 || hist_r != 0) ? 0 : hist_d;
      bad = ((qn != want_n) ? 1 : 0) + ((qs != want_s) ? 2 : 0) + ((qa != want_a) ? 4 : 0);
      if (bad != 0) begin
        if (m_fv[i] == 0) begin m_fc[i] = m_cyc[i]; m_fv[i] = 1; end
        m_mask[i] = m_mask[i] | bad;
        m_err[i]  = 1;
        if (m_ec[i] < ec_max[i]) m_ec[i]++;
      end
      if (m_cyc[i] < 65535) m_cyc[i]++;
      if (stop_on[i] != 0 && bad != 0) m_mode[i] = 3;
      else if (e == 0)                 m_mode[i] = 0;
    end
  endtask

  task automatic cmp(input int i, input int st, input int er, input int mk, input int ec,
                     input int cy, input int fc, input int fv);
    chk($sformatf("inst%0d_state", i), st, m_mode[i]);
    chk($sformatf("inst%0d_err", i), er, m_err[i]);
    chk($sformatf("inst%0d_mask", i), mk, m_mask[i]);
    chk($sformatf("inst%0d_err_cnt", i), ec, m_ec[i]);
    chk($sformatf("inst%0d_cyc_cnt", i), cy, m_cyc[i]);
    chk($sformatf("inst%0d_first_cyc", i), fc, m_fc[i]);
    chk($sformatf("inst%0d_first_valid", i), fv, m_fv[i]);
  endtask

  always @(posedge clk) begin
    int s_rst, s_en, s_dr, s_d, s_qn, s_qs, s_qa;
    s_rst = reset; s_en = en; s_dr = dut_rst; s_d = d;
    s_qn = q_n; s_qs = q_s; s_qa = q_a;
    for (int i = 0; i < 3; i++) model_step(i, s_rst, s_en, s_dr, s_qn, s_qs, s_qa);
    hist_d = (s_rst != 0) ? 0 : s_d;
    hist_r = (s_rst != 0) ? 0 : s_dr;
    #1;
    cmp(0, st0, er0, mk0, ec0, cy0, fc0, fv0);
    cmp(1, st1, er1, mk1, ec1, cy1, fc1, fv1);
    cmp(2, st2, er2, mk2, ec2, cy2, fc2, fv2);
  end

  // Drive one edge worth of inputs; returns at the following falling edge.
  task automatic cyc(input logic e, input logic r, input logic dd);
    en = e; dut_rst = r; d = dd;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic run_seq(input logic inject);
    logic [4:0] tail;
    tail = 5'b10110;
    cyc(1'b1, 1'b1, 1'b0);
    chk("lit_prime_state", st0, 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("lit_check_state", st0, 2);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    force_sync = inject;
    cyc(1'b1, 1'b0, 1'b1);
    force_sync = 1'b0;
    if (inject) begin
      chk("lit_sync_err", er0, 1);
      chk("lit_sync_mask", mk0, 3'b010);
      chk("lit_sync_err_cnt", ec0, 1);
      chk("lit_sync_first_cyc", fc0, 4);
      chk("lit_sync_first_valid", fv0, 1);
      chk("lit_stop_halt", st2, 3);
    end
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, tail[k]);
    chk("lit_run_cyc_cnt", cy0, 10);
    chk("lit_run_err_cnt", ec0, inject ? 1 : 0);
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("lit_reset_state", st0, 0);
    chk("lit_reset_err_cnt", ec0, 0);
    chk("lit_reset_cyc_cnt", cy0, 0);
    chk("lit_reset_valid", fv0, 0);
    reset = 1'b0;

    // Clean run, then the same run with a sync-reset fault at check cycle 4.
    run_seq(1'b0);
    chk("lit_clean_err", er0, 0);
    pulse_reset();
    run_seq(1'b1);

    // Async-reset fault: reset rises while the async output sticks high.
    pulse_reset();
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    force_async = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    chk("lit_async_mask", mk0, 3'b100);
    force_async = 1'b0;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("lit_async_mask_hold", mk0, 3'b100);
    chk("lit_async_first_cyc", fc0, 1);

    // Saturation: no-reset output inverted for six check cycles.
    pulse_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    inv_norst = 1'b1;
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'(k % 2));
    inv_norst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("lit_sat_err_cnt", ec1, 3);
    chk("lit_sat_mask", mk1, 3'b001);
    chk("lit_sat_first_cyc", fc1, 1);
    chk("lit_wide_err_cnt", ec0, 6);

    // Stop-on-error instance stays frozen while en toggles, then reset clears it.
    for (int k = 0; k < 5; k++) cyc(1'(k % 2), 1'b0, 1'(k / 2));
    chk("lit_halt_state", st2, 3);
    chk("lit_halt_cyc_cnt", cy2, 2);
    chk("lit_halt_err_cnt", ec2, 1);
    pulse_reset();
    chk("lit_halt_reset_state", st2, 0);
    chk("lit_halt_reset_err", er2, 0);
    chk("lit_halt_reset_cyc", cy2, 0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
